// File: rtl/dt_control_if.sv
// -----------------------------------------------------------------------------
// dt_control_if
// Bundles the button inputs and the dt / status outputs of dt_control.
//   btn       : raw buttons, active-high, asynchronous; [0]=decrease, [1]=increase
//   dt        : signed integration step, registered
//   dtChanged : one-cycle pulse when dt takes a new value
//   led       : [0] dt==dtMin, [1] dt==dtMax, [3:2] two bits below the sign of dt
// Modports: master drives btn (board / testbench side), slave is dt_control.
// -----------------------------------------------------------------------------
interface dt_control_if #(
    parameter int dtBits = 20
);
    logic [1:0]               btn;
    logic signed [dtBits-1:0] dt;
    logic                     dtChanged;
    logic [3:0]               led;

    modport master (output btn, input dt, dtChanged, led);
    modport slave  (input btn, output dt, dtChanged, led);
endinterface

// File: rtl/dt_control.sv
// -----------------------------------------------------------------------------
// dt_control
// Turns two board buttons into the integration step dt for the Lorenz
// integrator. Each button passes through a 2-FF synchroniser, a counter
// debouncer and a rising-edge detector; the resulting step events drive a
// saturating increment / decrement / restore update of the dt register.
//
// Ports:
//   clk   : system clock
//   rstN  : asynchronous active-low reset, released synchronously to clk
//   bus   : dt_control_if.slave (btn in; dt, dtChanged, led out)
//
// Optional feature, macro HOLD_REPEAT_EN:
//   defined   - a button held alone auto-repeats its step event repeatDelay
//               cycles after the press event, then every repeatPeriod cycles.
//   undefined - exactly one step event per press; no repeat logic is built.
// -----------------------------------------------------------------------------
module dt_control #(
    parameter int dtBits         = 20,
    parameter int dtInit         = 429497,
    parameter int dtMin          = 4295,
    parameter int dtMax          = 524287,
    parameter int dtStep         = 4295,
    parameter int debounceCycles = 120000
`ifdef HOLD_REPEAT_EN
    ,
    parameter int repeatDelay    = 6000000,
    parameter int repeatPeriod   = 600000
`endif
) (
    input  logic         clk,
    input  logic         rstN,
    dt_control_if.slave  bus
);

    // ---------------------------------------------------------------------
    // Types and constants
    // ---------------------------------------------------------------------
    localparam int CNT_W = $clog2(debounceCycles) + 1;

    typedef logic [CNT_W-1:0]         cnt_t;
    typedef logic signed [dtBits-1:0] dt_t;
    typedef logic signed [dtBits:0]   wide_t;   // one guard bit for over/underflow
    typedef enum logic {IDLE, APPLY} state_t;

    localparam cnt_t  DB_LAST = cnt_t'(debounceCycles - 1);
    localparam dt_t   DT_INIT = dt_t'(dtInit);
    localparam dt_t   DT_MIN  = dt_t'(dtMin);
    localparam dt_t   DT_MAX  = dt_t'(dtMax);
    localparam wide_t STEP_W  = wide_t'(dtStep);
    localparam wide_t MIN_W   = wide_t'(dtMin);
    localparam wide_t MAX_W   = wide_t'(dtMax);

    if (!(dtMin <= dtInit && dtInit <= dtMax &&
          longint'(dtMax) < (longint'(1) << (dtBits - 1)) && dtStep > 0))
    begin : g_bad_dt_params
        $error("dt_control: need dtMin <= dtInit <= dtMax < 2^(dtBits-1) and dtStep > 0");
    end

    function automatic logic [3:0] led_of(dt_t v);
        return {v[dtBits-2 -: 2], v == DT_MAX, v == DT_MIN};
    endfunction

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [1:0]            sync1_q, sync2_q;
    logic [1:0]            stable_q, stable_d;
    logic [1:0]            stable_dly_q;
    logic [1:0][CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic [1:0]            warm_q;              // sync pipeline holds real samples
    logic [1:0]            armed_q, armed_d;    // button seen released since reset
    logic [1:0]            press_evt, evt;
    logic                  restore;

    state_t                state_q, state_d;
    dt_t                   dt_q, dt_d;
    logic                  dt_changed_q, dt_changed_d;
    logic [3:0]            led_q, led_d;
    wide_t                 sum, diff;

    // ---------------------------------------------------------------------
    // Debounce and press-event detection
    // ---------------------------------------------------------------------
    // NOTE: every variable assigned in an always_comb gets a default first,
    // so no path can leave it unassigned and infer a latch.
    always_comb begin
        stable_d  = stable_q;
        db_cnt_d  = '0;
        armed_d   = armed_q;
        press_evt = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
            // A button held through reset must be released before it can
            // generate events; a level that rises while unarmed is ignored.
            if (warm_q[1] && !sync2_q[i] && !stable_q[i]) begin
                armed_d[i] = 1'b1;
            end
            press_evt[i] = stable_q[i] & ~stable_dly_q[i] & armed_q[i];
        end
    end

`ifdef HOLD_REPEAT_EN
    // ---------------------------------------------------------------------
    // Auto-repeat: counts cycles since the last event while exactly one
    // button is held. rep_started_q selects the initial delay or the period.
    // ---------------------------------------------------------------------
    localparam int REP_MAX = (repeatDelay > repeatPeriod) ? repeatDelay : repeatPeriod;
    localparam int REP_W   = $clog2(REP_MAX + 1) + 1;
    typedef logic [REP_W-1:0] rep_t;
    localparam rep_t REP_DELAY  = rep_t'(repeatDelay);
    localparam rep_t REP_PERIOD = rep_t'(repeatPeriod);

    logic [1:0][REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [1:0]            rep_started_q, rep_started_d;
    logic [1:0]            rep_evt;
    logic                  only_one;

    always_comb begin
        only_one      = stable_q[0] ^ stable_q[1];
        rep_evt       = '0;
        rep_cnt_d     = rep_cnt_q;
        rep_started_d = rep_started_q;
        for (int i = 0; i < 2; i++) begin
            rep_evt[i] = armed_q[i] & only_one & stable_q[i] &
                         (rep_cnt_q[i] == (rep_started_q[i] ? REP_PERIOD : REP_DELAY));
            if (!(armed_q[i] && only_one && stable_q[i]) || restore) begin
                rep_cnt_d[i]     = '0;
                rep_started_d[i] = 1'b0;
            end else if (rep_evt[i]) begin
                // The event cycle itself is cycle 0 of the next period.
                rep_cnt_d[i]     = rep_t'(1);
                rep_started_d[i] = 1'b1;
            end else begin
                rep_cnt_d[i]     = rep_cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rep_cnt_q     <= '0;
            rep_started_q <= '0;
        end else begin
            rep_cnt_q     <= rep_cnt_d;
            rep_started_q <= rep_started_d;
        end
    end

    assign evt = press_evt | rep_evt;
`else
    assign evt = press_evt;
`endif

    // ---------------------------------------------------------------------
    // Update FSM: a step event computes and writes dt at once (IDLE->APPLY);
    // APPLY is the cycle in which the new dt is visible, and it refreshes
    // the LED register from it.
    // ---------------------------------------------------------------------
    always_comb begin
        state_d      = IDLE;
        dt_d         = dt_q;
        dt_changed_d = 1'b0;
        led_d        = led_q;
        sum          = wide_t'(dt_q) + STEP_W;
        diff         = wide_t'(dt_q) - STEP_W;
        // Pressing one button while the other is held (or both together)
        // returns dt to its initial value.
        restore      = (evt[0] & (evt[1] | stable_q[1])) | (evt[1] & stable_q[0]);

        case (state_q)
            IDLE:    ;
            APPLY:   led_d = led_of(dt_q);
            default: ;
        endcase

        if (|evt) begin
            state_d = APPLY;
            if (restore) begin
                dt_d = DT_INIT;
            end else if (evt[1]) begin
                dt_d = (sum > MAX_W) ? DT_MAX : dt_t'(sum);
            end else begin
                dt_d = (diff < MIN_W) ? DT_MIN : dt_t'(diff);
            end
        end
        dt_changed_d = (dt_d != dt_q);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            db_cnt_q     <= '0;
            warm_q       <= '0;
            armed_q      <= '0;
            state_q      <= IDLE;
            dt_q         <= DT_INIT;
            dt_changed_q <= 1'b0;
            led_q        <= led_of(DT_INIT);
        end else begin
            sync1_q      <= bus.btn;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            db_cnt_q     <= db_cnt_d;
            warm_q       <= {warm_q[0], 1'b1};
            armed_q      <= armed_d;
            state_q      <= state_d;
            dt_q         <= dt_d;
            dt_changed_q <= dt_changed_d;
            led_q        <= led_d;
        end
    end

    assign bus.dt        = dt_q;
    assign bus.dtChanged = dt_changed_q;
    assign bus.led       = led_q;

endmodule

// File: tb/tb_dt_control.sv
// -----------------------------------------------------------------------------
// tb_dt_control
// Directed bench for dt_control with debounceCycles=4 (and, when
// HOLD_REPEAT_EN is defined, repeatDelay=10 / repeatPeriod=5).
// A table of press records covers the step, clamp and restore behaviour;
// hand-written sequences cover reset, bounce, reset mid-debounce and repeat.
// -----------------------------------------------------------------------------
module tb_dt_control;

    localparam int DT_INIT = 429497;
    localparam int DT_MIN  = 4295;
    localparam int DT_MAX  = 524287;
    localparam int DT_STEP = 4295;

    typedef struct {
        logic [1:0] btn;      // level applied for this record
        bit         rel;      // release all buttons afterwards
        int         exp_dt;   // dt after the update edge
        bit         exp_chg;  // dtChanged in the update cycle
    } vec_t;

    logic clk;
    logic rstN;
    int   n_vec;
    int   n_bad;
    int   pulse_cnt;
    int   exp_prev;
    vec_t vecs[$];

    dt_control_if #(.dtBits(20)) bus ();

    dt_control #(
        .debounceCycles(4)
`ifdef HOLD_REPEAT_EN
        ,
        .repeatDelay(10),
        .repeatPeriod(5)
`endif
    ) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial pulse_cnt = 0;
    always @(negedge clk) begin
        if (rstN && bus.dtChanged) pulse_cnt = pulse_cnt + 1;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] led_exp(int d);
        logic [31:0] v;
        v = d;
        return {v[18:17], d == DT_MAX, d == DT_MIN};
    endfunction

    function automatic vec_t mk(logic [1:0] b, bit r, int d, bit c);
        vec_t v;
        v.btn = b; v.rel = r; v.exp_dt = d; v.exp_chg = c;
        return v;
    endfunction

    task automatic do_reset();
        rstN    = 1'b0;
        bus.btn = 2'b00;
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        repeat (3) @(negedge clk);
        exp_prev = DT_INIT;
    endtask

    // Applies one record from a negedge: checks dt is untouched after 6 edges,
    // updated with the right pulse after 7, and the LED / pulse end after 8.
    task automatic apply_vec(input vec_t v, input string tag);
        bus.btn = v.btn;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check({tag, " dt before update"}, bus.dt, exp_prev);
        check({tag, " dtChanged before update"}, bus.dtChanged, 0);
        @(posedge clk);
        @(negedge clk);
        check({tag, " dt"}, bus.dt, v.exp_dt);
        check({tag, " dtChanged"}, bus.dtChanged, v.exp_chg);
        @(negedge clk);
        check({tag, " dtChanged width"}, bus.dtChanged, 0);
        check({tag, " led"}, bus.led, led_exp(v.exp_dt));
        exp_prev = v.exp_dt;
        if (v.rel) begin
            bus.btn = 2'b00;
            repeat (8) @(negedge clk);
        end
    endtask

    initial begin
        int cur;
        int nxt;
        int base;
        n_vec   = 0;
        n_bad   = 0;
        bus.btn = 2'b00;
        rstN    = 1'b0;

        // ---------------- table: increment to clamp, restore, decrement to clamp
        cur = DT_INIT;
        for (int i = 0; i < 24; i++) begin
            nxt = (cur + DT_STEP > DT_MAX) ? DT_MAX : cur + DT_STEP;
            vecs.push_back(mk(2'b10, 1'b1, nxt, nxt != cur));
            cur = nxt;
        end
        vecs.push_back(mk(2'b10, 1'b0, DT_MAX, 1'b0));   // hold increase at max
        vecs.push_back(mk(2'b11, 1'b1, DT_INIT, 1'b1));  // press decrease -> restore
        cur = DT_INIT;
        for (int i = 0; i < 100; i++) begin
            nxt = (cur - DT_STEP < DT_MIN) ? DT_MIN : cur - DT_STEP;
            vecs.push_back(mk(2'b01, 1'b1, nxt, nxt != cur));
            cur = nxt;
        end
        vecs.push_back(mk(2'b01, 1'b0, DT_MIN, 1'b0));   // hold decrease at min
        vecs.push_back(mk(2'b11, 1'b1, DT_INIT, 1'b1));  // press increase -> restore
        vecs.push_back(mk(2'b10, 1'b1, DT_INIT + DT_STEP, 1'b1));
        vecs.push_back(mk(2'b11, 1'b1, DT_INIT, 1'b1));  // both at once -> restore

        // ---------------- reset state, short toggles ignored
        repeat (2) @(negedge clk);
        check("dt in reset", bus.dt, DT_INIT);
        check("led in reset", bus.led, 4'b1100);
        do_reset();
        check("dt after reset", bus.dt, DT_INIT);
        check("dtChanged after reset", bus.dtChanged, 0);
        check("led[1:0] after reset", bus.led[1:0], 2'b00);
        @(posedge clk); base = pulse_cnt; @(negedge clk);
        bus.btn = 2'b10; @(negedge clk);
        bus.btn = 2'b00; @(negedge clk);
        bus.btn = 2'b10; @(negedge clk);
        bus.btn = 2'b00;
        repeat (12) @(negedge clk);
        check("dt after short toggles", bus.dt, DT_INIT);
        @(posedge clk);
        check("pulses after short toggles", pulse_cnt - base, 0);

        // ---------------- bounce on increase, then a steady press
        @(negedge clk);
        @(posedge clk); base = pulse_cnt; @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            bus.btn = 2'b10; repeat (2) @(negedge clk);
            bus.btn = 2'b00; repeat (2) @(negedge clk);
        end
        bus.btn = 2'b10;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("bounce dt before update", bus.dt, DT_INIT);
        @(posedge clk);
        @(negedge clk);
        check("bounce dt", bus.dt, 433792);
        check("bounce dtChanged", bus.dtChanged, 1);
        @(negedge clk);
        bus.btn = 2'b00;
        repeat (8) @(negedge clk);
        @(posedge clk);
        check("bounce pulse count", pulse_cnt - base, 1);
        @(negedge clk);

        // ---------------- reset in the middle of a debounce
        do_reset();
        apply_vec(mk(2'b10, 1'b1, DT_INIT + DT_STEP, 1'b1), "pre-reset press");
        bus.btn = 2'b10;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("mid-op dt before reset", bus.dt, DT_INIT + DT_STEP);
        rstN = 1'b0;
        #1;
        check("mid-op dt async reset", bus.dt, DT_INIT);
        check("mid-op led async reset", bus.led, 4'b1100);
        check("mid-op dtChanged async reset", bus.dtChanged, 0);
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        @(posedge clk); base = pulse_cnt;
        repeat (20) @(negedge clk);
        check("held-through-reset dt", bus.dt, DT_INIT);
        @(posedge clk);
        check("held-through-reset pulses", pulse_cnt - base, 0);
        @(negedge clk);
        bus.btn = 2'b00;
        repeat (10) @(negedge clk);
        exp_prev = DT_INIT;
        apply_vec(mk(2'b10, 1'b1, DT_INIT + DT_STEP, 1'b1), "re-press after reset");

        // ---------------- table-driven step / clamp / restore sequence
        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            apply_vec(vecs[i], $sformatf("vec%0d", i));
        end

`ifdef HOLD_REPEAT_EN
        // ---------------- auto-repeat while increase is held alone
        begin
            int pulse_at[$];
            int exp_at[6];
            exp_at = '{7, 17, 22, 27, 32, 37};
            do_reset();
            bus.btn = 2'b10;
            for (int e = 1; e <= 45; e++) begin
                @(posedge clk);
                @(negedge clk);
                if (bus.dtChanged) pulse_at.push_back(e);
                if (e == 31) bus.btn = 2'b00;
            end
            check("repeat pulse count", pulse_at.size(), 6);
            for (int i = 0; i < 6; i++) begin
                check($sformatf("repeat pulse %0d edge", i),
                      (i < pulse_at.size()) ? pulse_at[i] : -1, exp_at[i]);
            end
            check("repeat final dt", bus.dt, DT_INIT + 6 * DT_STEP);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
